// File: rtl/dram_arb_pkg.sv
// Shared types for the I/D-cache DRAM arbiter: FSM states, port IDs, the default
// watchdog limit and the round-robin pick function.
package dram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {PORT_IC = 1'b0, PORT_DC = 1'b1} port_t;

  localparam int DEFAULT_TIMEOUT = 64;

  // A tie goes to whichever port was not served last.
  function automatic port_t pick_port(input logic ic, input logic dc, input port_t last);
    port_t p;
    if (ic && dc) begin
      if (last == PORT_IC) p = PORT_DC;
      else                 p = PORT_IC;
    end else if (dc) begin
      p = PORT_DC;
    end else begin
      p = PORT_IC;
    end
    return p;
  endfunction
endpackage

// File: rtl/dram_arbiter_if.sv
// Cache-port and DRAM-port bundle for dram_arbiter; slave = arbiter view,
// master = the cache controllers plus the DRAM model.
interface dram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              ic_req, ic_we, ic_ack;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_wdata, ic_rdata;
  logic              dc_req, dc_we, dc_ack;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata, dc_rdata;
  logic              mem_cs, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              err;

  modport slave (
    input  ic_req, ic_we, ic_addr, ic_wdata,
    output ic_ack, ic_rdata,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    output dc_ack, dc_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output err
  );

  modport master (
    output ic_req, ic_we, ic_addr, ic_wdata,
    input  ic_ack, ic_rdata,
    output dc_req, dc_we, dc_addr, dc_wdata,
    input  dc_ack, dc_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  err
  );
endinterface

// File: rtl/dram_arb_watchdog.sv
// BUSY-cycle counter for the arbiter; flags timeout on the TIMEOUT-th BUSY cycle.
// Only instantiated when DRAM_ARB_WATCHDOG_EN is defined.
module dram_arb_watchdog
  import dram_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // Held at zero outside BUSY so every transaction starts counting from 0.
  always_ff @(posedge clk) begin
    if (!rst || !busy)  cnt <= '0;
    else if (!timeout)  cnt <= cnt + CW'(1);
  end

  assign timeout = busy && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port between the I-cache and D-cache.
// Define DRAM_ARB_WATCHDOG_EN to abort stuck DRAM transactions with err=1.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  dram_arbiter_if.slave  bus
);
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("dram_arbiter: TIMEOUT must be >= 2");
  end

  state_t            state;
  port_t             gnt, last_grant, pick;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata, rdata;
  logic              ic_ack_q, dc_ack_q, err_q;
  logic              busy, timeout;

  assign busy = (state == BUSY);
  assign pick = pick_port(bus.ic_req, bus.dc_req, last_grant);

`ifdef DRAM_ARB_WATCHDOG_EN
  dram_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= PORT_IC;
      last_grant <= PORT_IC;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: if (bus.ic_req || bus.dc_req) begin
          gnt   <= pick;
          state <= BUSY;
          if (pick == PORT_DC) begin
            lat_we    <= bus.dc_we;
            lat_addr  <= bus.dc_addr;
            lat_wdata <= bus.dc_wdata;
          end else begin
            lat_we    <= bus.ic_we;
            lat_addr  <= bus.ic_addr;
            lat_wdata <= bus.ic_wdata;
          end
        end
        // A real mem_ack beats a timeout landing in the same cycle.
        BUSY: if (bus.mem_ack || timeout) begin
          if (bus.mem_ack) begin
            if (!lat_we) rdata <= bus.mem_rdata;
          end else begin
            rdata <= '0;
            err_q <= 1'b1;
          end
          last_grant <= gnt;
          ic_ack_q   <= (gnt == PORT_IC);
          dc_ack_q   <= (gnt == PORT_DC);
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_cs    = busy;
  assign bus.mem_we    = lat_we;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.ic_ack    = ic_ack_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.ic_rdata  = rdata;
  assign bus.dc_rdata  = rdata;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: reads, ties, write-back, spurious ack, watchdog
// (DRAM_ARB_WATCHDOG_EN) and mid-transaction reset.
module tb_dram_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  localparam logic [127:0] RD0 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] RD1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] RD2 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] RD3 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
  localparam logic [127:0] RD4 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] WB  = {16{8'hA5}};
  localparam logic [127:0] JNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

  logic clk, rst;
  int   n_chk, n_fail;

  dram_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  dram_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Called in a BUSY cycle: idle `w` cycles, then one mem_ack cycle. Returns in DONE.
  task automatic serve(input int w, input logic [127:0] rd);
    tick(w);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs"}, bus.mem_cs, 1'b0);
    chk({tag, "_ica"}, bus.ic_ack, 1'b0);
    chk({tag, "_dca"}, bus.dc_ack, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0;
    bus.ic_req = 0; bus.ic_we = 0; bus.ic_addr = '0; bus.ic_wdata = '0;
    bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    tick(2);

    // reset state
    chk_idle("rst");
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, '0);
    chk("rst_rdata", bus.ic_rdata, '0);
    chk("rst_err", bus.err, 1'b0);
    rst = 1'b1;
    tick();

    // single I-cache read, DRAM acks 3 cycles after cs
    bus.ic_req = 1; bus.ic_addr = 32'h100;
    tick();
    chk("ic_cs", bus.mem_cs, 1'b1);
    chk("ic_addr", bus.mem_addr, 128'h100);
    chk("ic_we", bus.mem_we, 1'b0);
    tick(2);
    chk("ic_wait_cs", bus.mem_cs, 1'b1);
    chk("ic_wait_ack", bus.ic_ack, 1'b0);
    serve(1, RD0);
    chk("ic_ack", bus.ic_ack, 1'b1);
    chk("ic_rdata", bus.ic_rdata, RD0);
    chk("ic_dca", bus.dc_ack, 1'b0);
    chk("ic_cs_done", bus.mem_cs, 1'b0);
    chk("ic_err", bus.err, 1'b0);
    bus.ic_req = 0;
    tick();
    chk_idle("ic_after");

    // tie right after reset: D-cache first, then I-cache
    rst = 1'b0; tick(); rst = 1'b1;
    bus.ic_req = 1; bus.ic_addr = 32'h200;
    bus.dc_req = 1; bus.dc_addr = 32'h300;
    tick();
    chk("tie1_addr", bus.mem_addr, 128'h300);
    serve(0, RD1);
    chk("tie1_dca", bus.dc_ack, 1'b1);
    chk("tie1_ica", bus.ic_ack, 1'b0);
    chk("tie1_rd", bus.dc_rdata, RD1);
    bus.dc_req = 0;
    tick();
    chk("tie1_gap_cs", bus.mem_cs, 1'b0);
    tick();
    chk("tie1b_cs", bus.mem_cs, 1'b1);
    chk("tie1b_addr", bus.mem_addr, 128'h200);
    serve(1, RD2);
    chk("tie1b_ica", bus.ic_ack, 1'b1);
    chk("tie1b_dca", bus.dc_ack, 1'b0);
    chk("tie1b_rd", bus.ic_rdata, RD2);
    bus.ic_req = 0;
    tick();

    // second tie: last grant was I-cache, so D-cache again
    bus.ic_req = 1; bus.ic_addr = 32'h240;
    bus.dc_req = 1; bus.dc_addr = 32'h340;
    tick();
    chk("tie2_addr", bus.mem_addr, 128'h340);
    serve(0, RD3);
    chk("tie2_dca", bus.dc_ack, 1'b1);
    bus.dc_req = 0;
    tick(2);
    chk("tie2b_addr", bus.mem_addr, 128'h240);
    serve(0, RD4);
    chk("tie2b_ica", bus.ic_ack, 1'b1);
    chk("tie2b_rd", bus.ic_rdata, RD4);
    bus.ic_req = 0;
    tick();

    // D-cache write-back: stable we/wdata, rdata untouched
    bus.dc_req = 1; bus.dc_we = 1; bus.dc_addr = 32'h400; bus.dc_wdata = WB;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wb_cs", bus.mem_cs, 1'b1);
      chk("wb_we", bus.mem_we, 1'b1);
      chk("wb_wdata", bus.mem_wdata, WB);
      tick();
    end
    chk("wb_addr", bus.mem_addr, 128'h400);
    serve(0, JNK);
    chk("wb_dca", bus.dc_ack, 1'b1);
    chk("wb_rdata", bus.dc_rdata, RD4);
    bus.dc_req = 0; bus.dc_we = 0; bus.dc_wdata = '0;
    tick();

    // spurious mem_ack while idle
    bus.mem_ack = 1; bus.mem_rdata = JNK;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    chk_idle("spur");
    tick();
    chk_idle("spur2");
    chk("spur_rd", bus.ic_rdata, RD4);

    // watchdog: DRAM never acks
    bus.dc_req = 1; bus.dc_addr = 32'h600;
    tick();
    chk("wd_cs", bus.mem_cs, 1'b1);
`ifdef DRAM_ARB_WATCHDOG_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wd_wait_cs", bus.mem_cs, 1'b1);
      chk("wd_wait_dca", bus.dc_ack, 1'b0);
    end
    tick();
    chk("wd_dca", bus.dc_ack, 1'b1);
    chk("wd_err", bus.err, 1'b1);
    chk("wd_rd", bus.dc_rdata, '0);
    chk("wd_cs_drop", bus.mem_cs, 1'b0);
    chk("wd_ica", bus.ic_ack, 1'b0);
`else
    tick(20);
    chk("nowd_cs", bus.mem_cs, 1'b1);
    chk("nowd_dca", bus.dc_ack, 1'b0);
    serve(0, RD1);
    chk("nowd_dca_end", bus.dc_ack, 1'b1);
    chk("nowd_err", bus.err, 1'b0);
`endif
    bus.dc_req = 0;
    tick();
    chk("post_wd_err", bus.err, 1'b0);

    // reset mid-transaction, late mem_ack ignored
    bus.ic_req = 1; bus.ic_addr = 32'h500;
    tick(2);
    chk("mid_cs", bus.mem_cs, 1'b1);
    rst = 1'b0;
    tick();
    chk_idle("mid_rst");
    chk("mid_rd", bus.ic_rdata, '0);
    chk("mid_addr", bus.mem_addr, '0);
    rst = 1'b1; bus.ic_req = 0;
    bus.mem_ack = 1; bus.mem_rdata = JNK;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    chk_idle("mid_late");
    tick();
    chk_idle("mid_late2");
    chk("mid_late_rd", bus.ic_rdata, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "bench time limit");
  end
endmodule
